// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, memory funct3 codes and the
// load/store unit state and queue entry types.
package cpu_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_LW = 7'b0000011;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    // Widest completion tag an entry can carry.
    localparam int TAG_MAX = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } lsuState_t;

    typedef struct packed {
        logic               read;
        logic               write;
        logic [2:0]         funct3;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [TAG_MAX-1:0] tag;
    } lsuEntry_t;

    function automatic logic lsuIsError(lsuEntry_t e);
        logic badF3;
        logic misaligned;
        badF3 = (e.funct3 != F3_BYTE) && (e.funct3 != F3_WORD);
        misaligned = (e.funct3 == F3_WORD) && (e.addr[1:0] != 2'b00);
        return (e.read && e.write) || badF3 || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory request/grant/response bus between the LSU and memory.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_fifo.sv
// Synchronous FIFO of LSU queue entries; head is valid whenever
// the queue is non-empty.
module lsu_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  lsuEntry_t pushData,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output lsuEntry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    lsuEntry_t slots [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW:0] count;
    logic doPush;
    logic doPop;

    assign full = (count == CNT_FULL);
    assign empty = (count == '0);
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign head = slots[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            slots[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// In-order load/store unit: queues memory ops, runs one bus transaction
// at a time, steers byte lanes and broadcasts completions on the CDB.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic [2:0]         in_funct3,
    input  logic [31:0]        in_addr,
    input  logic [31:0]        in_wdata,
    input  logic [TAG_W-1:0]   in_tag,
    load_store_unit_if.master  mem,
    output logic               cdb_valid,
    input  logic               cdb_ready,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [31:0]        cdb_data,
    output logic               cdb_store,
    output logic               cdb_exc,
    output logic               busy
);

    lsuState_t state;
    lsuState_t nextState;
    lsuEntry_t inEntry;
    lsuEntry_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic headErr;
    logic isByte;
    logic [7:0] laneByte;
    logic [31:0] loadData;
    logic [31:0] result;
    logic unusedTag;

    assign inEntry = '{
        read:   in_mem_read,
        write:  in_mem_write,
        funct3: in_funct3,
        addr:   in_addr,
        wdata:  in_wdata,
        tag:    TAG_MAX'(in_tag)
    };

    // Entries with neither read nor write are accepted but never queued.
    assign in_ready = !full;
    assign push = in_valid && !full && (in_mem_read || in_mem_write);

    lsu_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pushData(inEntry),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign headErr = lsuIsError(head);
    assign isByte = (head.funct3 == F3_BYTE);
    assign laneByte = mem.mem_rdata[{head.addr[1:0], 3'b000} +: 8];
    assign loadData = isByte ? {{24{laneByte[7]}}, laneByte}
                             : mem.mem_rdata;
    assign busy = !empty || (state != S_IDLE);
    assign unusedTag = ^head.tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            result <= '0;
        end else begin
            state <= nextState;
            if (state == S_WAIT && mem.mem_rvalid) begin
                result <= loadData;
            end
        end
    end

    always_comb begin
        nextState = state;
        pop = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we = 1'b0;
        mem.mem_addr = '0;
        mem.mem_be = '0;
        mem.mem_wdata = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        cdb_store = 1'b0;
        cdb_exc = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    nextState = headErr ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                mem.mem_req = 1'b1;
                mem.mem_we = head.write;
                mem.mem_addr = {head.addr[31:2], 2'b00};
                mem.mem_be = (head.write && isByte)
                           ? (4'b0001 << head.addr[1:0]) : 4'b1111;
                mem.mem_wdata = isByte ? {4{head.wdata[7:0]}}
                                       : head.wdata;
                if (mem.mem_gnt) begin
                    nextState = head.write ? S_WB : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    nextState = S_WB;
                end
            end
            S_WB: begin
                cdb_valid = 1'b1;
                cdb_tag = head.tag[TAG_W-1:0];
                cdb_data = (head.write || headErr) ? '0 : result;
                cdb_store = head.write && !head.read;
                cdb_exc = headErr;
                if (cdb_ready) begin
                    pop = 1'b1;
                    nextState = S_IDLE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

endmodule
